// File: rtl/pool2x2_engine_pkg.sv
// conv_pkg: encodings shared by the CONV accelerator blocks.
//   pool_state_e : pooling FSM states (IDLE/RD/WR/FIN)
//   pool_mode_e  : reduction mode (max / average)
//   SEL_*        : memory bank select codes on csel
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } pool_state_e;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    localparam logic [2:0] SEL_NONE  = 3'b000;
    localparam logic [2:0] SEL_L0_K0 = 3'b001;
    localparam logic [2:0] SEL_L0_K1 = 3'b010;
    localparam logic [2:0] SEL_L1_K0 = 3'b011;
    localparam logic [2:0] SEL_L1_K1 = 3'b100;

endpackage

// File: rtl/pool2x2_engine_if.sv
// Memory bus between the pooling engine and the layer-0/layer-1 banks.
//   crd/caddr_rd/cdata_rd : read strobe, address, combinational read data
//   cwr/caddr_wr/cdata_wr : write strobe, address, data
//   csel                  : bank select for the current access
// master = engine side, slave = memory side.
interface pool2x2_engine_if #(
    parameter int AW = 12,
    parameter int DW = 20
);
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic [2:0]    csel;

    modport master (
        output crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
        input  cdata_rd
    );

    modport slave (
        input  crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
        output cdata_rd
    );
endinterface

// File: rtl/pool2x2_engine_reduce.sv
// pool_reduce: 4-sample max/average accumulator for one 2x2 window.
//   clk, reset  : clock, synchronous active-high reset
//   load        : first sample of a window (replaces accumulator)
//   accumulate  : subsequent samples
//   mode        : POOL_MAX or POOL_AVG
//   data        : sample value
//   result      : reduced window value (max, or floor(sum/4))
module pool_reduce
    import conv_pkg::*;
#(
    parameter int DW = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          accumulate,
    input  pool_mode_e    mode,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] result
);

    // Two guard bits so four full-scale samples never overflow the sum.
    logic [DW+1:0] acc_q, acc_d;
    logic [DW+1:0] data_ext;

    always_comb begin
        data_ext = {2'b00, data};
        acc_d    = acc_q;
        if (load) begin
            acc_d = data_ext;
        end else if (accumulate) begin
            if (mode == POOL_AVG) begin
                acc_d = acc_q + data_ext;
            end else if (data_ext > acc_q) begin
                acc_d = data_ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign result = (mode == POOL_AVG) ? acc_q[DW+1:2] : acc_q[DW-1:0];

endmodule

// File: rtl/pool2x2_engine.sv
// pool2x2_engine: 2x2 / stride-2 max or average pooling over NCH channels.
// Reads channel ch from bank SRC_SEL+ch, writes the pooled map to DST_SEL+ch.
//   clk, reset  : clock, synchronous active-high reset (aborts any run)
//   start, mode : one-cycle request; mode latched when start is accepted
//   busy, done  : busy from accepted start to last write; done pulses in FIN
//   mem         : memory bus master (read/write strobes, addresses, csel)
//
// state | meaning
// IDLE  | waiting for start, all strobes low
// RD    | reading window sample p (0..3), one per cycle
// WR    | writing the reduced window to the destination bank
// FIN   | one-cycle done pulse, busy low
module pool2x2_engine
    import conv_pkg::*;
#(
    parameter int         IMG_W   = 64,
    parameter int         IMG_H   = 64,
    parameter int         DW      = 20,
    parameter int         AW      = 12,
    parameter int         NCH     = 2,
    parameter logic [2:0] SRC_SEL = SEL_L0_K0,
    parameter logic [2:0] DST_SEL = SEL_L1_K0
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic mode,
    output logic busy,
    output logic done,
    pool2x2_engine_if.master mem
);

    localparam int OW  = IMG_W / 2;
    localparam int OH  = IMG_H / 2;
    localparam int OCW = (OW > 1) ? $clog2(OW) : 1;
    localparam int ORW = (OH > 1) ? $clog2(OH) : 1;

    localparam logic [OCW-1:0] OCOL_LAST = OCW'(OW - 1);
    localparam logic [ORW-1:0] OROW_LAST = ORW'(OH - 1);
    localparam logic [1:0]     CH_LAST   = 2'(NCH - 1);

    pool_state_e    state_q, state_d;
    logic [1:0]     p_q, p_d;
    logic [1:0]     ch_q, ch_d;
    logic [ORW-1:0] orow_q, orow_d;
    logic [OCW-1:0] ocol_q, ocol_d;
    pool_mode_e     mode_q, mode_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           crd_q, crd_d;
    logic           cwr_q, cwr_d;
    logic [AW-1:0]  caddr_rd_q, caddr_rd_d;
    logic [AW-1:0]  caddr_wr_q, caddr_wr_d;
    logic [2:0]     csel_q, csel_d;

    logic [1:0]     nxt_ch;
    logic [ORW-1:0] nxt_orow;
    logic [OCW-1:0] nxt_ocol;
    logic           last_win;
    logic [DW-1:0]  result;

    // Sample p of window (orow, ocol): p[1] selects the row, p[0] the column.
    function automatic logic [AW-1:0] rd_addr(input int orow, input int ocol, input int p);
        int a;
        a = (2 * orow + p / 2) * IMG_W + 2 * ocol + p % 2;
        return a[AW-1:0];
    endfunction

    function automatic logic [AW-1:0] wr_addr(input int orow, input int ocol);
        int a;
        a = orow * OW + ocol;
        return a[AW-1:0];
    endfunction

    always_comb begin
        nxt_ch   = ch_q;
        nxt_orow = orow_q;
        nxt_ocol = ocol_q;
        if (ocol_q == OCOL_LAST) begin
            nxt_ocol = '0;
            if (orow_q == OROW_LAST) begin
                nxt_orow = '0;
                nxt_ch   = ch_q + 2'd1;
            end else begin
                nxt_orow = orow_q + 1'b1;
            end
        end else begin
            nxt_ocol = ocol_q + 1'b1;
        end
    end

    assign last_win = (ch_q == CH_LAST) && (orow_q == OROW_LAST) && (ocol_q == OCOL_LAST);

    // Next-cycle outputs are computed here and registered, so each strobe,
    // address and select lines up with the state it belongs to.
    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        ch_d       = ch_q;
        orow_d     = orow_q;
        ocol_d     = ocol_q;
        mode_d     = mode_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        crd_d      = 1'b0;
        cwr_d      = 1'b0;
        caddr_rd_d = '0;
        caddr_wr_d = '0;
        csel_d     = SEL_NONE;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RD;
                    p_d        = 2'd0;
                    ch_d       = 2'd0;
                    orow_d     = '0;
                    ocol_d     = '0;
                    mode_d     = pool_mode_e'(mode);
                    busy_d     = 1'b1;
                    crd_d      = 1'b1;
                    caddr_rd_d = rd_addr(0, 0, 0);
                    csel_d     = SRC_SEL;
                end
            end
            RD: begin
                if (p_q != 2'd3) begin
                    p_d        = p_q + 2'd1;
                    crd_d      = 1'b1;
                    caddr_rd_d = rd_addr(int'(orow_q), int'(ocol_q), int'(p_q) + 1);
                    csel_d     = SRC_SEL + {1'b0, ch_q};
                end else begin
                    state_d    = WR;
                    cwr_d      = 1'b1;
                    caddr_wr_d = wr_addr(int'(orow_q), int'(ocol_q));
                    csel_d     = DST_SEL + {1'b0, ch_q};
                end
            end
            WR: begin
                p_d = 2'd0;
                if (last_win) begin
                    state_d = FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d    = RD;
                    ch_d       = nxt_ch;
                    orow_d     = nxt_orow;
                    ocol_d     = nxt_ocol;
                    crd_d      = 1'b1;
                    caddr_rd_d = rd_addr(int'(nxt_orow), int'(nxt_ocol), 0);
                    csel_d     = SRC_SEL + {1'b0, nxt_ch};
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            p_q        <= 2'd0;
            ch_q       <= 2'd0;
            orow_q     <= '0;
            ocol_q     <= '0;
            mode_q     <= POOL_MAX;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            caddr_rd_q <= '0;
            caddr_wr_q <= '0;
            csel_q     <= SEL_NONE;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            ch_q       <= ch_d;
            orow_q     <= orow_d;
            ocol_q     <= ocol_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            crd_q      <= crd_d;
            cwr_q      <= cwr_d;
            caddr_rd_q <= caddr_rd_d;
            caddr_wr_q <= caddr_wr_d;
            csel_q     <= csel_d;
        end
    end

    pool_reduce #(.DW(DW)) u_reduce (
        .clk        (clk),
        .reset      (reset),
        .load       (crd_q && (p_q == 2'd0)),
        .accumulate (crd_q && (p_q != 2'd0)),
        .mode       (mode_q),
        .data       (mem.cdata_rd),
        .result     (result)
    );

    // busy also covers the cycle in which start is accepted, so the
    // controller sees busy for the full NCH*windows*5 + 1 cycles.
    assign busy = busy_q | ((state_q == IDLE) & start & ~reset);
    assign done = done_q;

    assign mem.crd      = crd_q;
    assign mem.caddr_rd = caddr_rd_q;
    assign mem.cwr      = cwr_q;
    assign mem.caddr_wr = caddr_wr_q;
    assign mem.cdata_wr = cwr_q ? result : '0;
    assign mem.csel     = csel_q;

endmodule

// File: tb/tb_pool2x2_engine.sv
module tb_pool2x2_engine;
    import conv_pkg::*;

    typedef struct {
        logic [2:0]  sel;
        logic [11:0] addr;
        logic [19:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    logic start0, mode0, busy0, done0;
    logic start1, mode1, busy1, done1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [19:0] k0 [0:4095];
    logic [19:0] k1 [0:4095];
    logic [19:0] ks [0:31];

    wr_t sb0[$];
    wr_t sb1[$];

    int busy_cnt0 = 0, last_busy0 = 0, done_cnt0 = 0;
    int busy_cnt1 = 0, last_busy1 = 0, done_cnt1 = 0;

    always #5 clk = ~clk;

    pool2x2_engine_if #(.AW(12), .DW(20)) if0 ();
    pool2x2_engine_if #(.AW(12), .DW(20)) if1 ();

    pool2x2_engine u0 (
        .clk(clk), .reset(reset), .start(start0), .mode(mode0),
        .busy(busy0), .done(done0), .mem(if0)
    );

    pool2x2_engine #(.IMG_W(8), .IMG_H(4), .NCH(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .mode(mode1),
        .busy(busy1), .done(done1), .mem(if1)
    );

    assign if0.cdata_rd = (if0.csel == 3'd1) ? k0[if0.caddr_rd] :
                          (if0.csel == 3'd2) ? k1[if0.caddr_rd] : 20'd0;
    assign if1.cdata_rd = (if1.csel == 3'd1) ? ks[if1.caddr_rd[4:0]] : 20'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write scoreboards and bus-rule checks, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (if0.cwr) begin
                if (sb0.size() == 0) begin
                    check("wr0_unexpected", {20'd0, if0.caddr_wr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = sb0.pop_front();
                    check("wr0_sel", {29'd0, if0.csel}, {29'd0, e.sel});
                    check("wr0_addr", {20'd0, if0.caddr_wr}, {20'd0, e.addr});
                    check("wr0_data", {12'd0, if0.cdata_wr}, {12'd0, e.data});
                end
            end
            check("bus0_rd_and_wr", {31'd0, if0.crd & if0.cwr}, 32'd0);
            if (!if0.crd && !if0.cwr)
                check("bus0_idle_quiet", {9'd0, if0.csel, if0.cdata_wr}, 32'd0);
            if (if1.cwr) begin
                if (sb1.size() == 0) begin
                    check("wr1_unexpected", {20'd0, if1.caddr_wr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = sb1.pop_front();
                    check("wr1_sel", {29'd0, if1.csel}, {29'd0, e.sel});
                    check("wr1_addr", {20'd0, if1.caddr_wr}, {20'd0, e.addr});
                    check("wr1_data", {12'd0, if1.cdata_wr}, {12'd0, e.data});
                end
            end
            check("bus1_csel", {29'd0, if1.csel},
                  if1.crd ? 32'd1 : (if1.cwr ? 32'd3 : 32'd0));
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            busy_cnt0 = 0;
            busy_cnt1 = 0;
        end else begin
            if (busy0) busy_cnt0++;
            if (done0) begin
                last_busy0 = busy_cnt0;
                busy_cnt0  = 0;
                done_cnt0++;
            end
            if (busy1) busy_cnt1++;
            if (done1) begin
                last_busy1 = busy_cnt1;
                busy_cnt1  = 0;
                done_cnt1++;
            end
        end
    end

    task automatic push0(input logic [2:0] sel, input int addr, input logic [19:0] data);
        wr_t e;
        e.sel  = sel;
        e.addr = 12'(addr);
        e.data = data;
        sb0.push_back(e);
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 4096; a++) begin
            k0[a] = 20'd0;
            k1[a] = 20'd0;
        end
    endtask

    // Sparse map used by the max-mode runs: only three windows are non-zero.
    task automatic load_sparse_max();
        clear_mem();
        k0[0]   = 20'd7;
        k0[67]  = 20'd9;
        k1[654] = 20'hFFFFF;
        k1[655] = 20'hFFFFF;
        k1[718] = 20'hFFFFF;
        k1[719] = 20'hFFFFF;
    endtask

    task automatic push_sparse_max();
        for (int a = 0; a < 1024; a++)
            push0(3'd3, a, (a == 0) ? 20'd7 : (a == 1) ? 20'd9 : 20'd0);
        for (int a = 0; a < 1024; a++)
            push0(3'd4, a, (a == 167) ? 20'hFFFFF : 20'd0);
    endtask

    task automatic wait_done0(input int limit, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!done0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!done0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: done not seen within %0d cycles", tag, limit);
        end
    endtask

    task automatic start_run0(input logic m);
        @(posedge clk);
        #1 start0 = 1'b1;
        mode0 = m;
        @(posedge clk);
        #1 start0 = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start0 = 1'b0; mode0 = 1'b0;
        start1 = 1'b0; mode1 = 1'b0;
        for (int a = 0; a < 32; a++) ks[a] = 20'(a);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_strobes", {30'd0, if0.crd, if0.cwr}, 32'd0);
        check("rst_csel", {29'd0, if0.csel}, 32'd0);
        check("rst_addr", {8'd0, if0.caddr_rd, if0.caddr_wr}, 32'd0);
        check("rst_data", {12'd0, if0.cdata_wr}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Small map 8x4, one channel, max: 8 writes.
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) begin
                wr_t e;
                e.sel = 3'd3;
                e.addr = 12'(r * 4 + c);
                e.data = 20'((2 * r + 1) * 8 + 2 * c + 1);
                sb1.push_back(e);
            end
        @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!done1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("small_done_seen", {31'd0, done1}, 32'd1);
        @(negedge clk);
        check("small_busy_cycles", 32'(last_busy1), 32'd41);
        check("small_writes_left", 32'(sb1.size()), 32'd0);
        check("small_done_count", 32'(done_cnt1), 32'd1);

        // Run 1: max over address ramps, with start pulses while busy.
        for (int a = 0; a < 4096; a++) begin
            k0[a] = 20'(a);
            k1[a] = 20'(4095 - a);
        end
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                push0(3'd3, r * 32 + c, 20'((2 * r + 1) * 64 + 2 * c + 1));
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                push0(3'd4, r * 32 + c, 20'(4095 - (2 * r * 64 + 2 * c)));
        start_run0(1'b0);
        repeat (100) @(posedge clk);
        #1 start0 = 1'b1; mode0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0; mode0 = 1'b0;
        repeat (5000) @(posedge clk);
        #1 start0 = 1'b1; mode0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0; mode0 = 1'b0;
        wait_done0(12000, "run1_done");
        check("run1_writes_left", 32'(sb0.size()), 32'd0);

        // start held through FIN (ignored) and the next IDLE (accepted): run 2, average.
        start0 = 1'b1;
        mode0  = 1'b1;
        clear_mem();
        k0[0] = 20'd4; k0[1] = 20'd5; k0[64] = 20'd6; k0[65] = 20'd8;
        k0[2] = 20'hFFFFF; k0[3] = 20'hFFFFF; k0[66] = 20'hFFFFF; k0[67] = 20'hFFFFF;
        k0[128] = 20'd7;
        k1[4030] = 20'd1; k1[4031] = 20'd2; k1[4094] = 20'd3; k1[4095] = 20'd6;
        for (int a = 0; a < 1024; a++)
            push0(3'd3, a, (a == 0) ? 20'd5 : (a == 1) ? 20'hFFFFF : (a == 32) ? 20'd1 : 20'd0);
        for (int a = 0; a < 1024; a++)
            push0(3'd4, a, (a == 1023) ? 20'd3 : 20'd0);
        @(posedge clk);
        @(negedge clk);
        check("fin_start_ignored", {31'd0, if0.crd}, 32'd0);
        check("run1_busy_cycles", 32'(last_busy0), 32'd10241);
        check("run1_done_count", 32'(done_cnt0), 32'd1);
        @(posedge clk);
        #1 start0 = 1'b0;
        @(negedge clk);
        check("run2_first_crd", {31'd0, if0.crd}, 32'd1);
        check("run2_first_addr", {20'd0, if0.caddr_rd}, 32'd0);
        check("run2_first_csel", {29'd0, if0.csel}, 32'd1);
        wait_done0(12000, "run2_done");
        check("run2_writes_left", 32'(sb0.size()), 32'd0);
        @(negedge clk);
        check("run2_busy_cycles", 32'(last_busy0), 32'd10241);
        check("run2_done_count", 32'(done_cnt0), 32'd2);

        // Run 3: max mode, p0 must load rather than keep the previous window.
        repeat (3) @(posedge clk);
        load_sparse_max();
        push_sparse_max();
        start_run0(1'b0);
        wait_done0(12000, "run3_done");
        check("run3_writes_left", 32'(sb0.size()), 32'd0);

        // Run 4: aborted by reset around cycle 500.
        repeat (3) @(posedge clk);
        push_sparse_max();
        start_run0(1'b0);
        repeat (500) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sb0.delete();
        @(negedge clk);
        check("abort_busy", {31'd0, busy0}, 32'd0);
        check("abort_crd", {31'd0, if0.crd}, 32'd0);
        check("abort_cwr", {31'd0, if0.cwr}, 32'd0);
        check("abort_csel", {29'd0, if0.csel}, 32'd0);
        repeat (20) @(negedge clk);
        check("abort_stays_idle", {29'd0, busy0, if0.crd, if0.cwr}, 32'd0);

        // Run 5: full run after the abort must start from channel 0, window (0,0).
        push_sparse_max();
        start_run0(1'b0);
        wait_done0(12000, "run5_done");
        check("run5_writes_left", 32'(sb0.size()), 32'd0);
        @(negedge clk);
        check("run5_busy_cycles", 32'(last_busy0), 32'd10241);
        check("run5_done_after", {31'd0, done0}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
